eth_tx_framer: RTL and testbench



---
 rtl/eth_tx_framer.sv | 233 +++++++++++++++++++++++
 tb/tb_eth_tx_framer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_framer.sv
// Ethernet transmit framer: preamble, SFD, header, payload, pad and FCS onto a
// 2/4/8-bit PHY bus, with underrun/oversize abort and frame/error counters.
module eth_tx_framer #(
  parameter int          P_PHY_WIDTH   = 4,
  parameter logic [47:0] P_MAC_ADDR    = 48'h00183E02523A,
  parameter int          P_MIN_PAYLOAD = 46,
  parameter int          P_MAX_PAYLOAD = 1500,
  parameter int          P_IFG_BYTES   = 12
) (
  input  logic                   tx_clk,
  input  logic                   tx_rst,
  input  logic [7:0]             tx_byte,
  input  logic                   tx_byte_vld,
  input  logic                   tx_byte_last,
  output logic                   tx_byte_rdy,
  input  logic [47:0]            tx_dst_mac,
  input  logic [15:0]            tx_pkt_type,
  output logic [P_PHY_WIDTH-1:0] tx_data,
  output logic                   tx_en,
  output logic                   tx_er,
  output logic                   busy,
  output logic [15:0]            frame_cnt,
  output logic [15:0]            err_cnt
);

  localparam int             C         = 8 / P_PHY_WIDTH;
  localparam int             SW        = (C > 1) ? $clog2(C) : 1;
  localparam logic [SW-1:0]  LAST_SLOT = SW'(C - 1);
  localparam logic [15:0]    MIN16     = 16'(P_MIN_PAYLOAD);
  localparam logic [15:0]    MAX16     = 16'(P_MAX_PAYLOAD);
  localparam logic [15:0]    GAP_LOAD  = 16'(P_IFG_BYTES * C - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_SFD, S_DST, S_SRC, S_TYPE,
    S_PAYLOAD, S_PAD, S_FCS, S_ABORT, S_DRAIN, S_IFG
  } state_t;

  state_t        r_state;
  logic [7:0]    r_byte;
  logic [SW-1:0] r_slot;
  logic [2:0]    r_idx;
  logic [15:0]   r_cnt;
  logic [31:0]   r_crc;
  logic [47:0]   r_dst;
  logic [15:0]   r_type;
  logic          r_last;
  logic          r_under;
  logic          r_en;
  logic          r_er;
  logic [15:0]   r_gap;
  logic [15:0]   r_frame_cnt;
  logic [15:0]   r_err_cnt;

  logic w_last_slot;
  logic w_need_byte;

  function automatic logic [31:0] f_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] v;
    v = c;
    for (int i = 0; i < 8; i++)
      v = (v[0] ^ b[i]) ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
    return v;
  endfunction

  function automatic logic [7:0] f_byte48(input logic [47:0] v, input int i);
    return v[8*(5-i) +: 8];
  endfunction

  function automatic logic [7:0] f_byte32(input logic [31:0] v, input int i);
    return v[8*i +: 8];
  endfunction

  assign w_last_slot = (r_slot == LAST_SLOT);
  // The next payload byte is requested on the final slot of the byte before it.
  assign w_need_byte = w_last_slot &&
                       ((r_state == S_TYPE && r_idx == 3'd1) ||
                        (r_state == S_PAYLOAD && !r_last && r_cnt != MAX16));

  assign tx_byte_rdy = w_need_byte || (r_state == S_DRAIN);
  assign busy        = (r_state != S_IDLE);
  assign tx_data     = r_byte[int'(r_slot)*P_PHY_WIDTH +: P_PHY_WIDTH];
  assign tx_en       = r_en;
  assign tx_er       = r_er;
  assign frame_cnt   = r_frame_cnt;
  assign err_cnt     = r_err_cnt;

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      r_state     <= S_IDLE;
      r_byte      <= 8'h00;
      r_slot      <= '0;
      r_idx       <= 3'd0;
      r_cnt       <= 16'd0;
      r_crc       <= 32'hFFFFFFFF;
      r_dst       <= 48'd0;
      r_type      <= 16'd0;
      r_last      <= 1'b0;
      r_under     <= 1'b0;
      r_en        <= 1'b0;
      r_er        <= 1'b0;
      r_gap       <= 16'd0;
      r_frame_cnt <= 16'd0;
      r_err_cnt   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tx_byte_vld) begin
            r_state <= S_PRE;
            r_byte  <= 8'h55;
            r_slot  <= '0;
            r_idx   <= 3'd0;
            r_en    <= 1'b1;
            r_er    <= 1'b0;
            r_dst   <= tx_dst_mac;
            r_type  <= tx_pkt_type;
            r_crc   <= 32'hFFFFFFFF;
            r_cnt   <= 16'd0;
            r_last  <= 1'b0;
          end
        end
        S_IFG: begin
          if (r_gap == 16'd0) r_state <= S_IDLE;
          else                r_gap   <= r_gap - 16'd1;
        end
        S_DRAIN: begin
          if ((tx_byte_vld && tx_byte_last) || (r_under && !tx_byte_vld)) begin
            r_state <= S_IFG;
            r_gap   <= GAP_LOAD;
          end
        end
        default: begin
          if (!w_last_slot) begin
            r_slot <= r_slot + 1'b1;
          end else begin
            r_slot <= '0;
            case (r_state)
              S_PRE: begin
                if (r_idx == 3'd6) begin
                  r_state <= S_SFD;
                  r_byte  <= 8'hD5;
                end else begin
                  r_idx  <= r_idx + 3'd1;
                  r_byte <= 8'h55;
                end
              end
              S_SFD: begin
                r_state <= S_DST;
                r_idx   <= 3'd0;
                r_byte  <= f_byte48(r_dst, 0);
                r_crc   <= f_crc(r_crc, f_byte48(r_dst, 0));
              end
              S_DST: begin
                if (r_idx == 3'd5) begin
                  r_state <= S_SRC;
                  r_idx   <= 3'd0;
                  r_byte  <= f_byte48(P_MAC_ADDR, 0);
                  r_crc   <= f_crc(r_crc, f_byte48(P_MAC_ADDR, 0));
                end else begin
                  r_idx  <= r_idx + 3'd1;
                  r_byte <= f_byte48(r_dst, int'(r_idx) + 1);
                  r_crc  <= f_crc(r_crc, f_byte48(r_dst, int'(r_idx) + 1));
                end
              end
              S_SRC: begin
                if (r_idx == 3'd5) begin
                  r_state <= S_TYPE;
                  r_idx   <= 3'd0;
                  r_byte  <= r_type[15:8];
                  r_crc   <= f_crc(r_crc, r_type[15:8]);
                end else begin
                  r_idx  <= r_idx + 3'd1;
                  r_byte <= f_byte48(P_MAC_ADDR, int'(r_idx) + 1);
                  r_crc  <= f_crc(r_crc, f_byte48(P_MAC_ADDR, int'(r_idx) + 1));
                end
              end
              S_TYPE, S_PAYLOAD, S_PAD: begin
                if (r_state == S_TYPE && r_idx == 3'd0) begin
                  r_idx  <= 3'd1;
                  r_byte <= r_type[7:0];
                  r_crc  <= f_crc(r_crc, r_type[7:0]);
                end else if (r_state == S_PAD || (r_state == S_PAYLOAD && r_last)) begin
                  // Zero padding is covered by the CRC like payload.
                  if (r_cnt < MIN16) begin
                    r_state <= S_PAD;
                    r_byte  <= 8'h00;
                    r_cnt   <= r_cnt + 16'd1;
                    r_crc   <= f_crc(r_crc, 8'h00);
                  end else begin
                    r_state <= S_FCS;
                    r_idx   <= 3'd0;
                    r_byte  <= ~r_crc[7:0];
                  end
                end else if (w_need_byte && tx_byte_vld) begin
                  r_state <= S_PAYLOAD;
                  r_byte  <= tx_byte;
                  r_cnt   <= r_cnt + 16'd1;
                  r_last  <= tx_byte_last;
                  r_crc   <= f_crc(r_crc, tx_byte);
                end else begin
                  r_state <= S_ABORT;
                  r_byte  <= 8'h00;
                  r_er    <= 1'b1;
                  r_under <= w_need_byte;
                end
              end
              S_FCS: begin
                if (r_idx == 3'd3) begin
                  r_state     <= S_IFG;
                  r_en        <= 1'b0;
                  r_byte      <= 8'h00;
                  r_gap       <= GAP_LOAD;
                  r_frame_cnt <= r_frame_cnt + 16'd1;
                end else begin
                  r_idx  <= r_idx + 3'd1;
                  r_byte <= f_byte32(~r_crc, int'(r_idx) + 1);
                end
              end
              S_ABORT: begin
                r_state   <= S_DRAIN;
                r_en      <= 1'b0;
                r_er      <= 1'b0;
                r_byte    <= 8'h00;
                r_err_cnt <= r_err_cnt + 16'd1;
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: W=4 main instance plus W=2 and W=8 builds,
// checking frame length, header bytes, padding, FCS residue, aborts and reset.
module tb_eth_tx_framer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  txByte [3];
  logic        vld    [3];
  logic        last   [3];
  logic [47:0] dstMac;
  logic [15:0] pktType;
  logic        rdy    [3];
  logic        en     [3];
  logic        er     [3];
  logic        busyS  [3];
  logic [15:0] fcnt   [3];
  logic [15:0] ecnt   [3];
  logic [3:0]  d4;
  logic [1:0]  d2;
  logic [7:0]  d8;

  int checks = 0;
  int errors = 0;
  int enCycles, erCycles, rdyCnt, gapCycles, consumed;
  logic timedOut;
  logic [7:0] wireBytes [$];

  always #5 clk = ~clk;

  eth_tx_framer #(.P_PHY_WIDTH(4)) u_w4 (
    .tx_clk(clk), .tx_rst(rst), .tx_byte(txByte[0]), .tx_byte_vld(vld[0]),
    .tx_byte_last(last[0]), .tx_byte_rdy(rdy[0]), .tx_dst_mac(dstMac),
    .tx_pkt_type(pktType), .tx_data(d4), .tx_en(en[0]), .tx_er(er[0]),
    .busy(busyS[0]), .frame_cnt(fcnt[0]), .err_cnt(ecnt[0]));

  eth_tx_framer #(.P_PHY_WIDTH(2)) u_w2 (
    .tx_clk(clk), .tx_rst(rst), .tx_byte(txByte[1]), .tx_byte_vld(vld[1]),
    .tx_byte_last(last[1]), .tx_byte_rdy(rdy[1]), .tx_dst_mac(dstMac),
    .tx_pkt_type(pktType), .tx_data(d2), .tx_en(en[1]), .tx_er(er[1]),
    .busy(busyS[1]), .frame_cnt(fcnt[1]), .err_cnt(ecnt[1]));

  eth_tx_framer #(.P_PHY_WIDTH(8)) u_w8 (
    .tx_clk(clk), .tx_rst(rst), .tx_byte(txByte[2]), .tx_byte_vld(vld[2]),
    .tx_byte_last(last[2]), .tx_byte_rdy(rdy[2]), .tx_dst_mac(dstMac),
    .tx_pkt_type(pktType), .tx_data(d8), .tx_en(en[2]), .tx_er(er[2]),
    .busy(busyS[2]), .frame_cnt(fcnt[2]), .err_cnt(ecnt[2]));

  function automatic int widthOf(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 8;
  endfunction

  function automatic logic [7:0] dataOf(input int k);
    return (k == 0) ? {4'b0, d4} : (k == 1) ? {6'b0, d2} : d8;
  endfunction

  function automatic logic [31:0] crcRun(input int from);
    logic [31:0] c;
    logic [7:0]  b;
    c = 32'hFFFFFFFF;
    for (int i = from; i < wireBytes.size(); i++) begin
      b = wireBytes[i];
      for (int j = 0; j < 8; j++)
        c = (c[0] ^ b[j]) ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [47:0] gather48(input int from);
    logic [47:0] g;
    g = 48'd0;
    for (int j = 0; j < 6; j++) g = {g[39:0], wireBytes[from + j]};
    return g;
  endfunction

  task automatic checkOutput(input string tag, input logic [47:0] observed,
                             input logic [47:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame of n bytes (value = index) into instance k; source stops
  // at byte dropAt when dropAt >= 0. Captures wire bytes while tx_en && !tx_er.
  task automatic applyStimulus(input int k, input int n, input int dropAt);
    int idx, w, c, shiftCnt;
    logic [7:0] acc;
    logic started, done;
    w = widthOf(k); c = 8 / w;
    enCycles = 0; erCycles = 0; rdyCnt = 0; gapCycles = 0;
    wireBytes.delete();
    idx = 0; acc = 8'd0; shiftCnt = 0; started = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (busyS[k]) started = 1'b1;
      if (en[k]) begin
        enCycles++;
        if (er[k]) erCycles++;
        else begin
          acc = acc | (dataOf(k) << (shiftCnt * w));
          shiftCnt++;
          if (shiftCnt == c) begin
            wireBytes.push_back(acc);
            acc = 8'd0; shiftCnt = 0;
          end
        end
      end else if (started && busyS[k] && enCycles > 0) gapCycles++;
      if (rdy[k]) rdyCnt++;
      if (started && !busyS[k]) begin
        done = 1'b1;
        break;
      end
      if (idx < n && !(dropAt >= 0 && idx >= dropAt)) begin
        vld[k] = 1'b1; txByte[k] = idx[7:0]; last[k] = (idx == n - 1);
      end else begin
        vld[k] = 1'b0; txByte[k] = 8'h00; last[k] = 1'b0;
      end
      if (rdy[k] && vld[k]) idx++;
    end
    vld[k] = 1'b0; last[k] = 1'b0;
    consumed = idx;
    timedOut = !done;
    checkOutput("no_timeout", {47'd0, timedOut}, 48'd0);
  endtask

  initial begin
    logic ok;
    int cnt;
    rst = 1'b1;
    dstMac = 48'h0A1B2C3D4E5F;
    pktType = 16'h0800;
    for (int k = 0; k < 3; k++) begin
      txByte[k] = 8'h00; vld[k] = 1'b0; last[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checkOutput("reset_en", {47'd0, en[0]}, 48'd0);
    checkOutput("reset_er", {47'd0, er[0]}, 48'd0);
    checkOutput("reset_busy_rdy", {46'd0, busyS[0], rdy[0]}, 48'd0);
    checkOutput("reset_data", {40'd0, dataOf(0)}, 48'd0);
    checkOutput("reset_counters", {16'd0, fcnt[0], ecnt[0]}, 48'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] W=4 46-byte frame");
    applyStimulus(0, 46, -1);
    checkOutput("f46_en_cycles", 48'(enCycles), 48'd144);
    checkOutput("f46_bytes", 48'(wireBytes.size()), 48'd72);
    ok = 1'b1;
    for (int i = 0; i < 7; i++) if (wireBytes[i] != 8'h55) ok = 1'b0;
    checkOutput("f46_preamble", {47'd0, ok}, 48'd1);
    checkOutput("f46_sfd", {40'd0, wireBytes[7]}, 48'hD5);
    checkOutput("f46_dst", gather48(8), 48'h0A1B2C3D4E5F);
    checkOutput("f46_type", {32'd0, wireBytes[20], wireBytes[21]}, 48'h0800);
    ok = 1'b1;
    for (int i = 0; i < 46; i++) if (wireBytes[22 + i] != 8'(i)) ok = 1'b0;
    checkOutput("f46_payload", {47'd0, ok}, 48'd1);
    checkOutput("f46_residue", {16'd0, crcRun(8)}, 48'hDEBB20E3);
    checkOutput("f46_frame_cnt", {32'd0, fcnt[0]}, 48'd1);
    checkOutput("f46_ifg", 48'(gapCycles), 48'd24);
    checkOutput("f46_rdy", 48'(rdyCnt), 48'd46);

    $display("[TB] W=4 10-byte frame with padding");
    applyStimulus(0, 10, -1);
    checkOutput("f10_en_cycles", 48'(enCycles), 48'd144);
    checkOutput("f10_rdy", 48'(rdyCnt), 48'd10);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) if (wireBytes[22 + i] != 8'(i)) ok = 1'b0;
    for (int i = 32; i < 68; i++) if (wireBytes[i] != 8'h00) ok = 1'b0;
    checkOutput("f10_pad", {47'd0, ok}, 48'd1);
    checkOutput("f10_residue", {16'd0, crcRun(8)}, 48'hDEBB20E3);
    checkOutput("f10_frame_cnt", {32'd0, fcnt[0]}, 48'd2);

    $display("[TB] W=2 and W=8 52-byte frames");
    applyStimulus(1, 52, -1);
    checkOutput("w2_en_cycles", 48'(enCycles), 48'((8 + 14 + 52 + 4) * 4));
    checkOutput("w2_src", gather48(14), 48'h00183E02523A);
    checkOutput("w2_residue", {16'd0, crcRun(8)}, 48'hDEBB20E3);
    checkOutput("w2_frame_cnt", {32'd0, fcnt[1]}, 48'd1);
    applyStimulus(2, 52, -1);
    checkOutput("w8_en_cycles", 48'(enCycles), 48'((8 + 14 + 52 + 4) * 1));
    checkOutput("w8_src", gather48(14), 48'h00183E02523A);
    checkOutput("w8_residue", {16'd0, crcRun(8)}, 48'hDEBB20E3);
    checkOutput("w8_frame_cnt", {32'd0, fcnt[2]}, 48'd1);

    $display("[TB] underrun at payload byte 20");
    applyStimulus(0, 46, 20);
    checkOutput("ur_consumed", 48'(consumed), 48'd20);
    checkOutput("ur_bytes", 48'(wireBytes.size()), 48'd42);
    checkOutput("ur_er_cycles", 48'(erCycles), 48'd2);
    checkOutput("ur_err_cnt", {32'd0, ecnt[0]}, 48'd1);
    checkOutput("ur_frame_cnt", {32'd0, fcnt[0]}, 48'd2);
    checkOutput("ur_gap_min", {47'd0, (gapCycles >= 24)}, 48'd1);

    $display("[TB] oversize 1600-byte stream");
    applyStimulus(0, 1600, -1);
    checkOutput("ov_consumed", 48'(consumed), 48'd1600);
    checkOutput("ov_bytes", 48'(wireBytes.size()), 48'd1522);
    checkOutput("ov_er_cycles", 48'(erCycles), 48'd2);
    checkOutput("ov_en_cycles", 48'(enCycles), 48'(1522 * 2 + 2));
    checkOutput("ov_err_cnt", {32'd0, ecnt[0]}, 48'd2);
    checkOutput("ov_frame_cnt", {32'd0, fcnt[0]}, 48'd2);

    $display("[TB] reset during TYPE");
    vld[0] = 1'b1; txByte[0] = 8'h00; last[0] = 1'b0;
    cnt = 0;
    for (int cyc = 0; cyc < 200 && cnt < 41; cyc++) begin
      @(negedge clk);
      if (en[0]) cnt++;
    end
    checkOutput("rs_reached_type", 48'(cnt), 48'd41);
    rst = 1'b1; vld[0] = 1'b0;
    @(negedge clk);
    checkOutput("rs_en", {47'd0, en[0]}, 48'd0);
    checkOutput("rs_busy", {47'd0, busyS[0]}, 48'd0);
    checkOutput("rs_counters", {16'd0, fcnt[0], ecnt[0]}, 48'd0);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(0, 46, -1);
    checkOutput("rs_en_cycles", 48'(enCycles), 48'd144);
    checkOutput("rs_residue", {16'd0, crcRun(8)}, 48'hDEBB20E3);
    checkOutput("rs_frame_cnt", {32'd0, fcnt[0]}, 48'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
